// File: rtl/bus_master_port_pkg.sv
// Shared bus types and defaults for the AHB-Lite master port and its helpers.
package bus_master_port_pkg;

    typedef enum logic [1:0] {
        TransIdle   = 2'b00,
        TransBusy   = 2'b01,
        TransNonseq = 2'b10,
        TransSeq    = 2'b11
    } transfer_kind;

    typedef enum logic {
        RespOkay  = 1'b0,
        RespError = 1'b1
    } transfer_response;

    localparam int unsigned BUS_DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/bus_master.sv
// AHB-Lite master-side bundle between a master port and the bus controller/decoder.
interface bus_master;
    import bus_master_port_pkg::*;

    transfer_kind     trans;
    logic             write;
    logic [31:0]      address;
    logic [31:0]      write_data;
    logic             ready;
    transfer_response response;
    logic [31:0]      read_data;

    modport out (
        output trans, write, address, write_data,
        input  ready, response, read_data
    );

    modport slave (
        input  trans, write, address, write_data,
        output ready, response, read_data
    );

endinterface

// File: rtl/bus_watchdog.sv
// Saturating wait-state counter; expired flags TIMEOUT consecutive wait cycles (0 disables).
module bus_watchdog
    import bus_master_port_pkg::*;
#(
    parameter int unsigned TIMEOUT = BUS_DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic wait_cycle,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (wait_cycle && (count_q != LIMIT)) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign expired = (TIMEOUT != 0) && (count_q == LIMIT);

endmodule

// File: rtl/bus_master_port.sv
// Core valid/ready request stream to pipelined AHB-Lite master transfers with in-order responses.
module bus_master_port
    import bus_master_port_pkg::*;
#(
    parameter bit          PIPELINED = 1'b1,
    parameter int unsigned TIMEOUT   = BUS_DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        hung,
    bus_master.out      bus
);

    logic        a_valid_q, a_valid_d, a_write_q, a_write_d;
    logic [31:0] a_addr_q, a_addr_d, a_wdata_q, a_wdata_d;
    logic        d_valid_q, d_valid_d, d_write_q, d_write_d;
    logic [31:0] d_wdata_q, d_wdata_d;
    logic        cancel_q, cancel_d, hung_q, hung_d, orphan_q, orphan_d;
    logic        rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d, write_data_q, write_data_d;
    transfer_kind trans_q, trans_d;

    logic a_adv, d_done, accept, wait_cycle, bus_error, expired, fire, wd_clear;

    assign d_done     = d_valid_q && bus.ready;
    assign a_adv      = a_valid_q && !cancel_q && bus.ready;
    assign req_ready  = !hung_q && (!a_valid_q || a_adv) && (PIPELINED || !d_valid_q || d_done);
    assign accept     = req_valid && req_ready;
    assign wait_cycle = d_valid_q && !bus.ready;
    assign bus_error  = (bus.response == RespError);
    assign fire       = expired && d_valid_q;
    assign wd_clear   = d_done || fire;

    bus_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .wait_cycle(wait_cycle),
        .clear     (wd_clear),
        .expired   (expired)
    );

    always_comb begin
        a_valid_d   = a_valid_q;
        a_write_d   = a_write_q;
        a_addr_d    = a_addr_q;
        a_wdata_d   = a_wdata_q;
        d_valid_d   = d_valid_q;
        d_write_d   = d_write_q;
        d_wdata_d   = d_wdata_q;
        hung_d      = hung_q;
        orphan_d    = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_error_d = 1'b0;
        rsp_rdata_d = '0;
        // First ERROR cycle: the following cycle must drive IDLE on the bus.
        cancel_d    = wait_cycle && bus_error;

        if (fire) begin
            a_valid_d   = 1'b0;
            d_valid_d   = 1'b0;
            hung_d      = 1'b1;
            cancel_d    = 1'b0;
            orphan_d    = a_valid_q || accept;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
        end else begin
            if (d_done) begin
                d_valid_d   = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_error_d = bus_error;
                rsp_rdata_d = (!d_write_q && !bus_error) ? bus.read_data : '0;
            end
            if (a_adv) begin
                a_valid_d = 1'b0;
                d_valid_d = 1'b1;
                d_write_d = a_write_q;
                d_wdata_d = a_wdata_q;
            end
            if (accept) begin
                a_valid_d = 1'b1;
                a_write_d = req_write;
                a_addr_d  = req_addr;
                a_wdata_d = req_wdata;
            end
            // Request stranded in A by a watchdog timeout gets its error one cycle later.
            if (orphan_q) begin
                rsp_valid_d = 1'b1;
                rsp_error_d = 1'b1;
            end
        end

        trans_d      = (a_valid_d && !cancel_d) ? TransNonseq : TransIdle;
        write_data_d = (d_valid_d && d_write_d) ? d_wdata_d : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_valid_q    <= 1'b0;
            a_write_q    <= 1'b0;
            a_addr_q     <= '0;
            a_wdata_q    <= '0;
            d_valid_q    <= 1'b0;
            d_write_q    <= 1'b0;
            d_wdata_q    <= '0;
            cancel_q     <= 1'b0;
            hung_q       <= 1'b0;
            orphan_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_error_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            trans_q      <= TransIdle;
            write_data_q <= '0;
        end else begin
            a_valid_q    <= a_valid_d;
            a_write_q    <= a_write_d;
            a_addr_q     <= a_addr_d;
            a_wdata_q    <= a_wdata_d;
            d_valid_q    <= d_valid_d;
            d_write_q    <= d_write_d;
            d_wdata_q    <= d_wdata_d;
            cancel_q     <= cancel_d;
            hung_q       <= hung_d;
            orphan_q     <= orphan_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_error_q  <= rsp_error_d;
            rsp_rdata_q  <= rsp_rdata_d;
            trans_q      <= trans_d;
            write_data_q <= write_data_d;
        end
    end

    assign bus.trans      = trans_q;
    assign bus.write      = a_write_q;
    assign bus.address    = a_addr_q;
    assign bus.write_data = write_data_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_error      = rsp_error_q;
    assign hung           = hung_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port: PIPELINED=1, TIMEOUT=4, slave driven from the bench.
module tb_bus_master_port;
    import bus_master_port_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_error, hung;
    logic [31:0] rsp_rdata;

    int checks = 0;
    int errors = 0;

    bus_master bus ();

    bus_master_port #(
        .PIPELINED(1'b1),
        .TIMEOUT  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .hung     (hung),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic w, input logic [31:0] a,
                             input logic [31:0] d);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_req(1'b0, 1'b0, 32'h0, 32'h0);
        bus.ready = 1'b1;
        bus.response = RespOkay;
        bus.read_data = 32'h0;
        tick();
        tick();
        checks++;
        if (bus.trans !== TransIdle) begin
            errors++; $display("FAIL rst_trans: got %0d want %0d", bus.trans, TransIdle);
        end
        checks++;
        if (bus.write !== 1'b0 || bus.address !== 32'h0 || bus.write_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_bus: got w=%b a=%h wd=%h want 0/0/0",
                     bus.write, bus.address, bus.write_data);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0 || hung !== 1'b0) begin
            errors++;
            $display("FAIL rst_rsp: got v=%b d=%h e=%b h=%b want all 0",
                     rsp_valid, rsp_rdata, rsp_error, hung);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_ready: got %b want 1", req_ready);
        end
        tick();
    endtask

    task automatic test_single_read();
        drive_req(1'b1, 1'b0, 32'h100, 32'h0);
        tick();  // accepted, cycle 1
        drive_req(1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (bus.trans !== TransNonseq || bus.address !== 32'h100 || bus.write !== 1'b0) begin
            errors++;
            $display("FAIL rd_addr_phase: got t=%0d a=%h w=%b want 2/00000100/0",
                     bus.trans, bus.address, bus.write);
        end
        tick();  // cycle 2, data phase
        bus.read_data = 32'hDEADBEEF;
        checks++;
        if (bus.trans !== TransIdle || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rd_data_phase: got t=%0d v=%b want 0/0", bus.trans, rsp_valid);
        end
        tick();  // cycle 3
        bus.read_data = 32'h0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_error !== 1'b0) begin
            errors++;
            $display("FAIL rd_rsp: got v=%b d=%h e=%b want 1/deadbeef/0",
                     rsp_valid, rsp_rdata, rsp_error);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rd_pulse: got %b want 0", rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        drive_req(1'b1, 1'b1, 32'h200, 32'h11);
        tick();  // cycle 1: write in address phase
        drive_req(1'b1, 1'b0, 32'h204, 32'h0);
        #1;
        checks++;
        if (req_ready !== 1'b1 || bus.trans !== TransNonseq || bus.address !== 32'h200
            || bus.write !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: got r=%b t=%0d a=%h w=%b want 1/2/00000200/1",
                     req_ready, bus.trans, bus.address, bus.write);
        end
        tick();  // cycle 2: read address phase overlaps write data phase
        drive_req(1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (bus.trans !== TransNonseq || bus.address !== 32'h204 || bus.write !== 1'b0
            || bus.write_data !== 32'h11) begin
            errors++;
            $display("FAIL b2b_second: got t=%0d a=%h w=%b wd=%h want 2/00000204/0/00000011",
                     bus.trans, bus.address, bus.write, bus.write_data);
        end
        tick();  // cycle 3
        bus.read_data = 32'h55;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0
            || bus.write_data !== 32'h0 || bus.trans !== TransIdle) begin
            errors++;
            $display("FAIL b2b_rsp_wr: got v=%b e=%b d=%h wd=%h t=%0d want 1/0/0/0/0",
                     rsp_valid, rsp_error, rsp_rdata, bus.write_data, bus.trans);
        end
        tick();  // cycle 4
        bus.read_data = 32'h0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h55 || rsp_error !== 1'b0) begin
            errors++;
            $display("FAIL b2b_rsp_rd: got v=%b d=%h e=%b want 1/00000055/0",
                     rsp_valid, rsp_rdata, rsp_error);
        end
        tick();
    endtask

    task automatic test_wait_states();
        drive_req(1'b1, 1'b0, 32'h300, 32'h0);
        tick();  // cycle 1
        drive_req(1'b0, 1'b0, 32'h0, 32'h0);
        tick();  // cycle 2: data phase of 0x300, slave stalls
        bus.ready = 1'b0;
        drive_req(1'b1, 1'b0, 32'h304, 32'h0);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL ws_accept_empty_a: got %b want 1", req_ready);
        end
        tick();  // cycles 3 and 4: A full, still waiting
        drive_req(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (req_ready !== 1'b0 || bus.trans !== TransNonseq || bus.address !== 32'h304
                || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL ws_hold%0d: got r=%b t=%0d a=%h v=%b want 0/2/00000304/0",
                         i, req_ready, bus.trans, bus.address, rsp_valid);
            end
            tick();
        end
        bus.ready = 1'b1;  // cycle 5: release
        bus.read_data = 32'hCAFE0300;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL ws_release_ready: got %b want 1", req_ready);
        end
        tick();  // cycle 6
        bus.read_data = 32'hBEEF0304;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE0300 || rsp_error !== 1'b0) begin
            errors++;
            $display("FAIL ws_rsp0: got v=%b d=%h e=%b want 1/cafe0300/0",
                     rsp_valid, rsp_rdata, rsp_error);
        end
        tick();  // cycle 7
        bus.read_data = 32'h0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hBEEF0304) begin
            errors++;
            $display("FAIL ws_rsp1: got v=%b d=%h want 1/beef0304", rsp_valid, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_error();
        drive_req(1'b1, 1'b0, 32'h400, 32'h0);
        tick();  // cycle 1
        drive_req(1'b1, 1'b0, 32'h404, 32'h0);
        tick();  // cycle 2: first error cycle for 0x400
        drive_req(1'b0, 1'b0, 32'h0, 32'h0);
        bus.ready = 1'b0;
        bus.response = RespError;
        checks++;
        if (bus.trans !== TransNonseq || bus.address !== 32'h404) begin
            errors++;
            $display("FAIL err_queued: got t=%0d a=%h want 2/00000404", bus.trans, bus.address);
        end
        tick();  // cycle 3: second error cycle
        bus.ready = 1'b1;
        #1;
        checks++;
        if (bus.trans !== TransIdle || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_cancel: got t=%0d r=%b v=%b want 0/0/0",
                     bus.trans, req_ready, rsp_valid);
        end
        tick();  // cycle 4: 0x404 reissued
        bus.response = RespOkay;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL err_rsp: got v=%b e=%b d=%h want 1/1/0", rsp_valid, rsp_error, rsp_rdata);
        end
        checks++;
        if (bus.trans !== TransNonseq || bus.address !== 32'h404) begin
            errors++;
            $display("FAIL err_reissue: got t=%0d a=%h want 2/00000404", bus.trans, bus.address);
        end
        tick();  // cycle 5
        bus.read_data = 32'h00404404;
        checks++;
        if (rsp_valid !== 1'b0 || bus.trans !== TransIdle) begin
            errors++; $display("FAIL err_gap: got v=%b t=%0d want 0/0", rsp_valid, bus.trans);
        end
        tick();  // cycle 6
        bus.read_data = 32'h0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 32'h00404404) begin
            errors++;
            $display("FAIL err_second_rsp: got v=%b e=%b d=%h want 1/0/00404404",
                     rsp_valid, rsp_error, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_timeout();
        drive_req(1'b1, 1'b0, 32'h500, 32'h0);
        tick();  // cycle 1
        drive_req(1'b1, 1'b0, 32'h504, 32'h0);
        tick();  // cycle 2: 0x500 in data phase, 0x504 in A; slave never readies
        drive_req(1'b0, 1'b0, 32'h0, 32'h0);
        bus.ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b0 || hung !== 1'b0) begin
                errors++;
                $display("FAIL to_wait%0d: got v=%b h=%b want 0/0", i, rsp_valid, hung);
            end
            tick();
        end
        // cycle 7: forced error for 0x500
        drive_req(1'b1, 1'b0, 32'h508, 32'h0);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== 32'h0 || hung !== 1'b1) begin
            errors++;
            $display("FAIL to_rsp: got v=%b e=%b d=%h h=%b want 1/1/0/1",
                     rsp_valid, rsp_error, rsp_rdata, hung);
        end
        checks++;
        if (bus.trans !== TransIdle || req_ready !== 1'b0) begin
            errors++; $display("FAIL to_idle: got t=%0d r=%b want 0/0", bus.trans, req_ready);
        end
        tick();  // cycle 8: held request answered
        checks++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b1) begin
            errors++; $display("FAIL to_orphan: got v=%b e=%b want 1/1", rsp_valid, rsp_error);
        end
        tick();  // cycle 9
        checks++;
        if (rsp_valid !== 1'b0 || hung !== 1'b1 || bus.trans !== TransIdle || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL to_sticky: got v=%b h=%b t=%0d r=%b want 0/1/0/0",
                     rsp_valid, hung, bus.trans, req_ready);
        end
        drive_req(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset_mid();
        rst = 1'b0;
        bus.ready = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (hung !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rm_clear_hung: got h=%b r=%b want 0/1", hung, req_ready);
        end
        drive_req(1'b1, 1'b0, 32'h600, 32'h0);
        tick();  // cycle 1
        drive_req(1'b1, 1'b0, 32'h604, 32'h0);
        tick();  // cycle 2: 0x600 waiting, 0x604 in A
        drive_req(1'b0, 1'b0, 32'h0, 32'h0);
        bus.ready = 1'b0;
        tick();  // cycle 3: still waiting
        checks++;
        if (bus.trans !== TransNonseq) begin
            errors++; $display("FAIL rm_pre: got t=%0d want 2", bus.trans);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.trans !== TransIdle || rsp_valid !== 1'b0 || hung !== 1'b0) begin
            errors++;
            $display("FAIL rm_async: got t=%0d v=%b h=%b want 0/0/0", bus.trans, rsp_valid, hung);
        end
        tick();
        tick();
        rst = 1'b1;
        bus.ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL rm_ready: got %b want 1", req_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0 || bus.trans !== TransIdle) begin
                errors++;
                $display("FAIL rm_quiet%0d: got v=%b t=%0d want 0/0", i, rsp_valid, bus.trans);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_wait_states();
        test_error();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
